seq_div_stage: RTL and testbench
================================

Name: seq_div_stage

Overview:
- Iterative unsigned restoring divider that sits directly downstream of the operand bus feeding the combinational add/sub/mul stage.
- Consumes the same i_value_a / i_value_b pair and produces a registered quotient and remainder.
- Takes one quotient bit per clock, so the timing-critical combinational divide is removed from the high-frequency path.
- Uses a valid/ready handshake on both sides so the surrounding pipeline can stall it.

Parameters:
- DATA_WIDTH, 8, width of dividend, divisor, quotient and remainder.
- CNT_WIDTH, 16, width of the optional completed-operation counter.

Ports:
- i_clk  input  1  clock, rising-edge active.
- i_rstn  input  1  reset, asynchronous, active-low.
- i_valid  input  1  upstream operand pair valid.
- o_ready  output  1  block can accept operands.
- i_value_a  input  DATA_WIDTH  dividend.
- i_value_b  input  DATA_WIDTH  divisor.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts result.
- o_quotient  output  DATA_WIDTH  quotient a/b.
- o_remainder  output  DATA_WIDTH  remainder a%b.
- o_div_by_zero  output  1  result came from b==0.
- o_busy  output  1  state is not IDLE.
- o_op_count  output  CNT_WIDTH  completed results; present only with the macro.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rstn is asynchronous and active-low.
- Reset values: state=IDLE, o_ready=1, o_valid=0, o_quotient=0, o_remainder=0, o_div_by_zero=0, o_busy=0, internal registers 0.
- States: IDLE, RUN, DONE.
- o_ready=1 only in IDLE. o_valid=1 only in DONE. o_busy=(state!=IDLE).
- IDLE, accept (i_valid && o_ready at edge E0):
  - Latch a and b.
  - If b!=0: clear the partial remainder, load the bit counter with DATA_WIDTH-1, go to RUN.
  - If b==0: set o_quotient to all ones, o_remainder=a, o_div_by_zero=1, go straight to DONE. o_valid is high after E0.
- RUN, once per edge:
  - Shift {rem, dividend} left by 1.
  - If the shifted rem >= b: subtract b and shift in quotient bit 1; otherwise shift in 0.
  - The trial subtract is DATA_WIDTH+1 bits wide, so there is no overflow on rem near 2^DATA_WIDTH.
  - Decrement the counter. After the DATA_WIDTH-th RUN edge, register the quotient and remainder, set o_div_by_zero=0, go to DONE.
  - Latency from E0 to o_valid rising: exactly DATA_WIDTH+1 edges (9 for the default).
- DONE:
  - o_quotient, o_remainder and o_div_by_zero are held stable while i_ready=0; there is no timeout.
  - On an edge with o_valid && i_ready, go to IDLE; o_valid drops after that edge.
  - Outputs keep their last values in IDLE (not cleared).
- No overlap: a new operand is accepted at the earliest one edge after result handoff. Minimum period is DATA_WIDTH+2 edges for b!=0, 2 for b==0.
- Inputs are ignored outside IDLE; i_value_a / i_value_b may change freely during RUN.
- i_valid in IDLE while i_rstn is asserted is ignored.
- Reset mid-operation (RUN or DONE): immediate return to reset values. The partial result is discarded and no o_valid is produced.
- Width rules: unsigned only. For b!=0, quotient <= a, so there is no quotient overflow.

Optional Feature:
- Macro: SEQ_DIV_STAGE_CNT_EN.
- Defined:
  - o_op_count port exists, reset to 0.
  - Increments by 1 on every output handshake (o_valid && i_ready), including divide-by-zero results.
  - Wraps from all ones to 0.
- Undefined: the port and the counter logic are absent. All other behaviour is identical.

Test Plan:
- 200 / 7 accepted at E0 -> o_valid high after E0+9, o_quotient=28, o_remainder=4, o_div_by_zero=0, o_ready low throughout.
- 5 / 0 -> o_valid high after E0+1, o_quotient=255, o_remainder=5, o_div_by_zero=1. With the macro, o_op_count goes 0 to 1 at handoff.
- Boundaries: 255/1 -> 255 r0; 3/10 -> 0 r3; 255/255 -> 1 r0; 0/9 -> 0 r0.
- Backpressure: 100/3 with i_ready low for 5 cycles after o_valid -> outputs stay 33 r1. Handoff on the first i_ready edge, o_ready high on the next cycle. Operand changes during RUN do not affect the result.
- Reset mid-operation: deassert i_rstn 4 edges into RUN of 200/7 -> all outputs return to reset values immediately, and no o_valid follows release. Next op 50/6 -> 8 r2.
- Back-to-back stream (i_valid held high, i_ready high) of 10 random pairs plus b=0 cases -> each result matches a/b and a%b. Accept spacing is exactly 10 edges (b!=0) or 2 edges (b==0).

Source files
------------

// File: rtl/seq_div_stage.sv
// Iterative unsigned restoring divider with valid/ready handshake, one quotient bit per clock.
// Define SEQ_DIV_STAGE_CNT_EN to add the o_op_count completed-result counter.
module seq_div_stage #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_value_a,
    input  logic [DATA_WIDTH-1:0] i_value_b,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_quotient,
    output logic [DATA_WIDTH-1:0] o_remainder,
    output logic                  o_div_by_zero,
`ifdef SEQ_DIV_STAGE_CNT_EN
    output logic [CNT_WIDTH-1:0]  o_op_count,
`endif
    output logic                  o_busy
);

    localparam int unsigned BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BCW-1:0] BIT_LOAD = BCW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   dividend_q, dividend_d;
    logic [DATA_WIDTH-1:0]   divisor_q, divisor_d;
    logic [DATA_WIDTH-1:0]   rem_q, rem_d;
    logic [BCW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]   quotient_q, quotient_d;
    logic [DATA_WIDTH-1:0]   remainder_q, remainder_d;
    logic                    dbz_q, dbz_d;

    logic [DATA_WIDTH:0]     shifted;
    logic [DATA_WIDTH:0]     trial;
    logic                    qbit;
    logic [DATA_WIDTH-1:0]   rem_next;
    logic [DATA_WIDTH-1:0]   quo_next;

    // Partial remainder is always < divisor, so the shifted value fits DATA_WIDTH+1 bits and
    // the trial subtract's top bit is a clean borrow flag.
    always_comb begin
        shifted  = {rem_q, dividend_q[DATA_WIDTH-1]};
        trial    = shifted - {1'b0, divisor_q};
        qbit     = ~trial[DATA_WIDTH];
        rem_next = qbit ? trial[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
        quo_next = {dividend_q[DATA_WIDTH-2:0], qbit};
    end

    always_comb begin
        state_d     = state_q;
        dividend_d  = dividend_q;
        divisor_d   = divisor_q;
        rem_d       = rem_q;
        bit_cnt_d   = bit_cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        case (state_q)
            StIdle: begin
                if (i_valid) begin
                    dividend_d = i_value_a;
                    divisor_d  = i_value_b;
                    if (i_value_b != '0) begin
                        rem_d     = '0;
                        bit_cnt_d = BIT_LOAD;
                        state_d   = StRun;
                    end else begin
                        quotient_d  = '1;
                        remainder_d = i_value_a;
                        dbz_d       = 1'b1;
                        state_d     = StDone;
                    end
                end
            end
            StRun: begin
                dividend_d = quo_next;
                rem_d      = rem_next;
                bit_cnt_d  = bit_cnt_q - BCW'(1);
                if (bit_cnt_q == '0) begin
                    quotient_d  = quo_next;
                    remainder_d = rem_next;
                    dbz_d       = 1'b0;
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (i_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= StIdle;
            dividend_q  <= '0;
            divisor_q   <= '0;
            rem_q       <= '0;
            bit_cnt_q   <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dividend_q  <= dividend_d;
            divisor_q   <= divisor_d;
            rem_q       <= rem_d;
            bit_cnt_q   <= bit_cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

`ifdef SEQ_DIV_STAGE_CNT_EN
    logic [CNT_WIDTH-1:0] op_count_q;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            op_count_q <= '0;
        end else if (state_q == StDone && i_ready) begin
            op_count_q <= op_count_q + CNT_WIDTH'(1);
        end
    end

    assign o_op_count = op_count_q;
`endif

    assign o_ready       = (state_q == StIdle);
    assign o_valid       = (state_q == StDone);
    assign o_busy        = (state_q != StIdle);
    assign o_quotient    = quotient_q;
    assign o_remainder   = remainder_q;
    assign o_div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div_stage.sv
// Directed self-checking bench for seq_div_stage; honours SEQ_DIV_STAGE_CNT_EN when defined.
module tb_seq_div_stage;

    localparam int DW = 8;
    localparam int CW = 16;

    logic          i_clk = 1'b0;
    logic          i_rstn = 1'b1;
    logic          i_valid = 1'b0;
    logic          o_ready;
    logic [DW-1:0] i_value_a = '0;
    logic [DW-1:0] i_value_b = '0;
    logic          o_valid;
    logic          i_ready = 1'b0;
    logic [DW-1:0] o_quotient;
    logic [DW-1:0] o_remainder;
    logic          o_div_by_zero;
    logic          o_busy;
`ifdef SEQ_DIV_STAGE_CNT_EN
    logic [CW-1:0] o_op_count;
`endif

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;

    seq_div_stage #(
        .DATA_WIDTH(DW),
        .CNT_WIDTH (CW)
    ) dut (
        .i_clk        (i_clk),
        .i_rstn       (i_rstn),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_value_a    (i_value_a),
        .i_value_b    (i_value_b),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_quotient   (o_quotient),
        .o_remainder  (o_remainder),
        .o_div_by_zero(o_div_by_zero),
`ifdef SEQ_DIV_STAGE_CNT_EN
        .o_op_count   (o_op_count),
`endif
        .o_busy       (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_count();
`ifdef SEQ_DIV_STAGE_CNT_EN
        check_eq("op_count", 32'(o_op_count), 32'(exp_cnt));
`endif
    endtask

    // One full transaction: accept, wait for result, check it, then hand off.
    task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] q, input logic [DW-1:0] r,
                          input logic dbz, input int lat_exp);
        int lat;
        logic ready_low;
        check_eq("pre_ready", 32'(o_ready), 32'd1);
        i_valid   = 1'b1;
        i_value_a = a;
        i_value_b = b;
        tick();
        i_valid   = 1'b0;
        i_value_a = 8'hA5;
        i_value_b = 8'h00;
        lat       = 1;
        ready_low = 1'b1;
        while (!o_valid && lat < 20) begin
            if (o_ready) ready_low = 1'b0;
            tick();
            lat++;
        end
        if (o_ready) ready_low = 1'b0;
        check_eq("latency", 32'(lat), 32'(lat_exp));
        check_eq("ready_low", 32'(ready_low), 32'd1);
        check_eq("busy", 32'(o_busy), 32'd1);
        check_eq("quotient", 32'(o_quotient), 32'(q));
        check_eq("remainder", 32'(o_remainder), 32'(r));
        check_eq("div_by_zero", 32'(o_div_by_zero), 32'(dbz));
        check_count();
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        exp_cnt++;
        check_eq("post_valid", 32'(o_valid), 32'd0);
        check_eq("post_ready", 32'(o_ready), 32'd1);
        check_eq("hold_quotient", 32'(o_quotient), 32'(q));
        check_count();
    endtask

    localparam int NS = 12;
    logic [DW-1:0] sa [NS];
    logic [DW-1:0] sb [NS];

    initial begin
        int lat;
        int cyc;
        int n_acc;
        int n_res;
        int last_acc;
        logic prev_ready;
        logic saw_valid;
        logic [DW-1:0] eq;
        logic [DW-1:0] er;

        // Reset values
        #2 i_rstn = 1'b0;
        #1;
        check_eq("rst_ready", 32'(o_ready), 32'd1);
        check_eq("rst_valid", 32'(o_valid), 32'd0);
        check_eq("rst_quotient", 32'(o_quotient), 32'd0);
        check_eq("rst_remainder", 32'(o_remainder), 32'd0);
        check_eq("rst_dbz", 32'(o_div_by_zero), 32'd0);
        check_eq("rst_busy", 32'(o_busy), 32'd0);
        check_count();
        // i_valid during reset must be ignored
        i_valid   = 1'b1;
        i_value_a = 8'd9;
        i_value_b = 8'd2;
        tick();
        tick();
        check_eq("rst_ignore_valid", 32'(o_busy), 32'd0);
        i_valid = 1'b0;
        i_rstn  = 1'b1;
        tick();

        // Main function and boundaries
        run_op(8'd5,   8'd0,   8'd255, 8'd5, 1'b1, 1);
        run_op(8'd200, 8'd7,   8'd28,  8'd4, 1'b0, 9);
        run_op(8'd255, 8'd1,   8'd255, 8'd0, 1'b0, 9);
        run_op(8'd3,   8'd10,  8'd0,   8'd3, 1'b0, 9);
        run_op(8'd255, 8'd255, 8'd1,   8'd0, 1'b0, 9);
        run_op(8'd0,   8'd9,   8'd0,   8'd0, 1'b0, 9);
        run_op(8'd254, 8'd255, 8'd0,   8'd254, 1'b0, 9);

        // Backpressure with operand churn during RUN
        i_valid   = 1'b1;
        i_value_a = 8'd100;
        i_value_b = 8'd3;
        tick();
        lat = 1;
        while (!o_valid && lat < 20) begin
            i_value_a = 8'(lat * 37);
            i_value_b = 8'(lat * 11);
            tick();
            lat++;
        end
        i_valid = 1'b0;
        check_eq("bp_latency", 32'(lat), 32'd9);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("bp_valid", 32'(o_valid), 32'd1);
            check_eq("bp_quotient", 32'(o_quotient), 32'd33);
            check_eq("bp_remainder", 32'(o_remainder), 32'd1);
        end
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        exp_cnt++;
        check_eq("bp_handoff_valid", 32'(o_valid), 32'd0);
        check_eq("bp_handoff_ready", 32'(o_ready), 32'd1);
        check_count();

        // Reset mid-operation
        i_valid   = 1'b1;
        i_value_a = 8'd200;
        i_value_b = 8'd7;
        tick();
        i_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        i_rstn = 1'b0;
        exp_cnt = 0;
        #1;
        check_eq("midrst_ready", 32'(o_ready), 32'd1);
        check_eq("midrst_valid", 32'(o_valid), 32'd0);
        check_eq("midrst_quotient", 32'(o_quotient), 32'd0);
        check_eq("midrst_remainder", 32'(o_remainder), 32'd0);
        check_eq("midrst_busy", 32'(o_busy), 32'd0);
        check_count();
        tick();
        i_rstn = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (o_valid || o_busy) saw_valid = 1'b1;
        end
        check_eq("midrst_no_valid", 32'(saw_valid), 32'd0);
        run_op(8'd50, 8'd6, 8'd8, 8'd2, 1'b0, 9);

        // Back-to-back stream
        for (int i = 0; i < NS; i++) begin
            sa[i] = 8'($urandom_range(0, 255));
            sb[i] = 8'($urandom_range(1, 255));
        end
        sb[3]  = 8'd0;
        sb[7]  = 8'd0;
        sb[8]  = 8'd0;
        i_ready    = 1'b1;
        i_valid    = 1'b1;
        i_value_a  = sa[0];
        i_value_b  = sb[0];
        prev_ready = o_ready;
        n_acc      = 0;
        n_res      = 0;
        cyc        = 0;
        last_acc   = 0;
        while (n_res < NS && cyc < 400) begin
            tick();
            cyc++;
            if (prev_ready && i_valid) begin
                if (n_acc > 0) begin
                    check_eq("stream_spacing", 32'(cyc - last_acc),
                             (sb[n_acc-1] != 0) ? 32'd10 : 32'd2);
                end
                last_acc = cyc;
                n_acc++;
                if (n_acc < NS) begin
                    i_value_a = sa[n_acc];
                    i_value_b = sb[n_acc];
                end else begin
                    i_valid = 1'b0;
                end
            end
            if (o_valid) begin
                if (sb[n_res] == 0) begin
                    eq = 8'd255;
                    er = sa[n_res];
                end else begin
                    eq = sa[n_res] / sb[n_res];
                    er = sa[n_res] % sb[n_res];
                end
                check_eq("stream_quotient", 32'(o_quotient), 32'(eq));
                check_eq("stream_remainder", 32'(o_remainder), 32'(er));
                check_eq("stream_dbz", 32'(o_div_by_zero), (sb[n_res] == 0) ? 32'd1 : 32'd0);
                n_res++;
                exp_cnt++;
            end
            prev_ready = o_ready;
        end
        check_eq("stream_results", 32'(n_res), 32'(NS));
        i_ready = 1'b0;
        tick();
        check_count();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
